// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } arb_state_e;

   // Cycles of tx_busy=0 after tx_start before the transmitter is declared dead.
   localparam int unsigned TIMEOUT_CYC = 4;
   localparam int unsigned TO_CNT_W    = $clog2(TIMEOUT_CYC);

endpackage

// File: rtl/rr_priority.sv
// Rotating-priority selector: first asserted request after ptr, wrapping modulo R.
module rr_priority #(
   parameter int unsigned R = 4
) (
   input  logic [R-1:0]         req,
   input  logic [$clog2(R)-1:0] ptr,
   output logic [$clog2(R)-1:0] winner,
   output logic                 valid
);

   localparam int unsigned PW = $clog2(R);

   // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
   always_comb begin
      winner = '0;
      valid  = |req;
      for (int i = R; i >= 1; i--) begin
         int idx;
         idx = (int'(ptr) + i) % int'(R);
         if (req[idx]) begin
            winner = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_transmitter from R requesters.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned R = 4,
   parameter int unsigned W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [R-1:0]         req,
   input  logic [R*W-1:0]       req_data,
   output logic [R-1:0]         ack,
   output logic                 tx_start,
   output logic [W-1:0]         tx_data,
   input  logic                 tx_busy,
   output logic [$clog2(R)-1:0] grant_id,
   output logic                 active,
   output logic                 timeout
);

   localparam int unsigned PW = $clog2(R);

   arb_state_e          state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       grant_q, grant_d;
   logic [W-1:0]        data_q, data_d;
   logic [R-1:0]        ack_q, ack_d;
   logic                start_q, start_d;
   logic                active_q, active_d;
   logic                timeout_q, timeout_d;
   logic [TO_CNT_W-1:0] cnt_q, cnt_d;

   logic [PW-1:0]       win;
   logic                win_valid;
   logic [W-1:0]        words [R];

   rr_priority #(.R(R)) u_rr (
      .req    (req),
      .ptr    (ptr_q),
      .winner (win),
      .valid  (win_valid)
   );

   always_comb begin
      for (int k = 0; k < int'(R); k++) begin
         words[k] = req_data[k*W +: W];
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      ack_d     = '0;
      start_d   = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_valid && !tx_busy) begin
               data_d       = words[win];
               ack_d[win]   = 1'b1;
               start_d      = 1'b1;
               grant_d      = win;
               ptr_d        = win;
               cnt_d        = '0;
               state_d      = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1)) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + TO_CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      active_d = (state_d != ST_IDLE);
   end

   // Reset starts the pointer at R-1 so the first grant favours index 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= PW'(R - 1);
         grant_q   <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         ack_q     <= '0;
         start_q   <= 1'b0;
         active_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         start_q   <= start_d;
         active_q  <= active_d;
         timeout_q <= timeout_d;
      end
   end

   assign ack      = ack_q;
   assign tx_start = start_q;
   assign tx_data  = data_q;
   assign grant_id = grant_q;
   assign active   = active_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with R=4, W=16.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] req_data;
   logic [3:0]  ack;
   logic        tx_start;
   logic [15:0] tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout;

   int checks   = 0;
   int failures = 0;

   logic [15:0] words [4];

   uart_tx_arbiter #(.R(4), .W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .grant_id (grant_id),
      .active   (active),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Grant to requester id, then emulate a transmitter busy for three cycles.
   task automatic serve(input int unsigned id);
      logic [3:0] exp_ack;
      exp_ack = 4'b0001 << id;
      tick();
      chk("grant_start",  64'(tx_start), 64'(1));
      chk("grant_ack",    64'(ack),      64'(exp_ack));
      chk("grant_id",     64'(grant_id), 64'(id));
      chk("grant_data",   64'(tx_data),  64'(words[id]));
      chk("grant_active", 64'(active),   64'(1));
      tx_busy = 1'b1;
      tick();
      chk("busy_start_low", 64'(tx_start), 64'(0));
      chk("busy_ack_low",   64'(ack),      64'(0));
      tick();
      tick();
      chk("busy_active", 64'(active),  64'(1));
      chk("busy_data",   64'(tx_data), 64'(words[id]));
      tx_busy = 1'b0;
      tick();
      chk("done_active",  64'(active),  64'(0));
      chk("done_timeout", 64'(timeout), 64'(0));
   endtask

   initial begin
      words[0] = 16'h1110;
      words[1] = 16'h2221;
      words[2] = 16'hBEEF;
      words[3] = 16'h4443;
      req_data = {words[3], words[2], words[1], words[0]};
      rst      = 1'b1;
      req      = 4'b0000;
      tx_busy  = 1'b0;

      // Reset values
      #1 rst = 1'b0;
      #2;
      chk("rst_ack",      64'(ack),      64'(0));
      chk("rst_start",    64'(tx_start), 64'(0));
      chk("rst_data",     64'(tx_data),  64'(0));
      chk("rst_grant",    64'(grant_id), 64'(0));
      chk("rst_active",   64'(active),   64'(0));
      chk("rst_timeout",  64'(timeout),  64'(0));
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("idle_no_ack", 64'(ack), 64'(0));

      // All requesting: strict rotation 0,1,2,3,0
      req = 4'b1111;
      serve(0);
      serve(1);
      serve(2);
      serve(3);
      serve(0);
      req = 4'b0000;

      // Single requester 2 with BEEF
      req = 4'b0100;
      serve(2);
      req = 4'b0000;

      // Move ptr to 3, then wrap to 0 and back to 3
      req = 4'b1000;
      serve(3);
      req = 4'b1001;
      serve(0);
      serve(3);
      req = 4'b0000;

      // Transmitter never goes busy: timeout after four cycles
      req = 4'b0010;
      tick();
      chk("to_grant_ack", 64'(ack), 64'(4'b0010));
      req = 4'b0000;
      tick();
      chk("to_wait1", 64'(timeout), 64'(0));
      tick();
      chk("to_wait2", 64'(timeout), 64'(0));
      tick();
      chk("to_wait3",        64'(timeout), 64'(0));
      chk("to_wait3_active", 64'(active),  64'(1));
      tick();
      chk("to_pulse",        64'(timeout),  64'(1));
      chk("to_pulse_active", 64'(active),   64'(0));
      chk("to_pulse_start",  64'(tx_start), 64'(0));
      req = 4'b0100;
      tick();
      chk("to_after_timeout", 64'(timeout),  64'(0));
      chk("to_next_start",    64'(tx_start), 64'(1));
      chk("to_next_ack",      64'(ack),      64'(4'b0100));
      chk("to_next_grant",    64'(grant_id), 64'(2));
      req = 4'b0000;
      tx_busy = 1'b1;
      tick();
      tx_busy = 1'b0;
      tick();
      chk("to_next_done", 64'(active), 64'(0));

      // Busy transmitter while idle holds off the grant
      tx_busy = 1'b1;
      req = 4'b0001;
      tick();
      chk("hold_ack1", 64'(ack), 64'(0));
      tick();
      chk("hold_ack2",    64'(ack),      64'(0));
      chk("hold_start2",  64'(tx_start), 64'(0));
      chk("hold_active2", 64'(active),   64'(0));
      tx_busy = 1'b0;
      tick();
      chk("hold_grant_ack", 64'(ack),      64'(4'b0001));
      chk("hold_grant_id",  64'(grant_id), 64'(0));
      req = 4'b0000;
      tx_busy = 1'b1;
      tick();
      tx_busy = 1'b0;
      tick();

      // Reset while in WAIT_DONE
      req = 4'b0100;
      tick();
      chk("mid_grant_ack", 64'(ack), 64'(4'b0100));
      req = 4'b0000;
      tx_busy = 1'b1;
      tick();
      chk("mid_active", 64'(active), 64'(1));
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_ack",     64'(ack),      64'(0));
      chk("mid_rst_start",   64'(tx_start), 64'(0));
      chk("mid_rst_data",    64'(tx_data),  64'(0));
      chk("mid_rst_grant",   64'(grant_id), 64'(0));
      chk("mid_rst_active",  64'(active),   64'(0));
      chk("mid_rst_timeout", 64'(timeout),  64'(0));
      tick();
      chk("mid_held_ack",     64'(ack),     64'(0));
      chk("mid_held_timeout", 64'(timeout), 64'(0));
      req = 4'b0110;
      tx_busy = 1'b0;
      rst = 1'b1;
      tick();
      chk("post_rst_start", 64'(tx_start), 64'(1));
      chk("post_rst_ack",   64'(ack),      64'(4'b0010));
      chk("post_rst_grant", 64'(grant_id), 64'(1));
      chk("post_rst_data",  64'(tx_data),  64'(16'h2221));
      req = 4'b0000;
      tx_busy = 1'b1;
      tick();
      tx_busy = 1'b0;
      tick();
      chk("post_rst_done", 64'(active), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
